// File: rtl/reduce_seq_pkg.sv
// Shared definitions for reduce_seq: reduction opcodes and FSM state encoding.
// Imported by the RTL and by the testbench, so both use the same encodings.
package reduce_seq_pkg;

  // Reduction opcodes. Bit 1 selects the OR family, which is evaluated through
  // the AND gate on inverted input (De Morgan).
  typedef enum logic [1:0] {
    OpAnd  = 2'd0,
    OpNand = 2'd1,
    OpOr   = 2'd2,
    OpNor  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // The final value is the inverse of the AND accumulator for NAND and OR.
  function automatic logic op_inverts_result(op_e op);
    return op[0] ^ op[1];
  endfunction

endpackage

// File: rtl/and_nway.sv
// N-input AND gate shared by the sequential reducer.
// Ports:
//   din  - NB_IN input bits
//   dout - AND of all input bits
module and_nway #(
  parameter int unsigned NB_IN = 8
) (
  input  logic [NB_IN-1:0] din,
  output logic             dout
);

  assign dout = &din;

endmodule

// File: rtl/reduce_seq.sv
// Sequential AND/NAND/OR/NOR reduction of a WIDTH-bit operand using a single
// NB_IN-input AND gate, one chunk per cycle, with early exit once the
// accumulator reaches zero.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   start_valid/start_ready   - request handshake (op, operand)
//   result_valid/result_ready - result handshake (result, chunks_used)
//   chunks_used               - number of chunks evaluated for the result
//   busy                      - high whenever the FSM is not idle
// WIDTH must be a non-zero multiple of NB_IN, with NB_IN >= 2.
module reduce_seq
  import reduce_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NB_IN = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_valid,
  output logic                            start_ready,
  input  logic [1:0]                      op,
  input  logic [WIDTH-1:0]                operand,
  output logic                            result_valid,
  input  logic                            result_ready,
  output logic                            result,
  output logic [$clog2(WIDTH/NB_IN):0]    chunks_used,
  output logic                            busy
);

  localparam int unsigned NCHUNK = WIDTH / NB_IN;
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned CW     = $clog2(NCHUNK) + 1;

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] opnd_q;
  logic [IW-1:0]    idx_q;
  logic             acc_q;
  logic [CW-1:0]    cu_q;
  logic             result_q;

  logic [NB_IN-1:0] chunk;
  logic             gate_out;
  logic             acc_new;
  logic             last_chunk;

  // OR family: invert the chunk so the AND gate computes NOR of the raw bits.
  assign chunk      = opnd_q[idx_q*NB_IN +: NB_IN] ^ {NB_IN{op_q[1]}};
  assign acc_new    = acc_q & gate_out;
  assign last_chunk = (idx_q == IW'(NCHUNK - 1));

  and_nway #(
    .NB_IN (NB_IN)
  ) u_and_nway (
    .din  (chunk),
    .dout (gate_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= OpAnd;
      opnd_q   <= '0;
      idx_q    <= '0;
      acc_q    <= 1'b1;
      cu_q     <= '0;
      result_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_valid) begin
            op_q    <= op_e'(op);
            opnd_q  <= operand;
            idx_q   <= '0;
            acc_q   <= 1'b1;
            cu_q    <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q <= acc_new;
          cu_q  <= cu_q + CW'(1);
          idx_q <= idx_q + IW'(1);
          if (!acc_new || last_chunk) begin
            result_q <= acc_new ^ op_inverts_result(op_q);
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (result_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign start_ready  = (state_q == StIdle);
  assign result_valid = (state_q == StDone);
  assign busy         = (state_q != StIdle);
  assign result       = result_q;
  assign chunks_used  = cu_q;

endmodule

// File: tb/tb_reduce_seq.sv
// Self-checking bench for reduce_seq (WIDTH=32, NB_IN=8): directed vector
// table, backpressure and mid-run reset sequences, random and exhaustive
// top-byte sweeps against a behavioural reduction model.
module tb_reduce_seq;
  import reduce_seq_pkg::*;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned NB_IN  = 8;
  localparam int unsigned NCHUNK = WIDTH / NB_IN;
  localparam int          BUDGET = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [1:0]  op;
  logic [31:0] operand;
  logic        result_valid;
  logic        result_ready;
  logic        result;
  logic [2:0]  chunks_used;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  reduce_seq #(
    .WIDTH (WIDTH),
    .NB_IN (NB_IN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .op           (op),
    .operand      (operand),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .chunks_used  (chunks_used),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] operand;
    logic        exp_result;
    int          exp_cu;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Reference: plain reduction over the whole word; chunk count is the
  // position of the first chunk that decides the answer, else all chunks.
  task automatic model(input logic [1:0] o, input logic [31:0] v,
                       output logic r, output int cu);
    logic [7:0] ch;
    cu = NCHUNK;
    for (int c = NCHUNK - 1; c >= 0; c--) begin
      ch = v[c*8 +: 8];
      if ((o <= 2'd1) ? (ch != 8'hFF) : (ch != 8'h00)) cu = c + 1;
    end
    case (o)
      2'd0:    r = &v;
      2'd1:    r = ~&v;
      2'd2:    r = |v;
      default: r = ~|v;
    endcase
  endtask

  // Counts negedges after the handshake edge until result_valid is seen.
  task automatic wait_valid(output int lat, output bit timed_out);
    lat = 1;
    while (!result_valid && lat < BUDGET) begin
      @(negedge clk);
      lat++;
    end
    timed_out = !result_valid;
  endtask

  // Full transaction starting and ending on a negedge in IDLE.
  task automatic do_req(input logic [1:0] o, input logic [31:0] v,
                        output logic r, output int cu, output int lat);
    bit to;
    start_valid = 1'b1;
    op          = o;
    operand     = v;
    @(negedge clk);
    start_valid = 1'b0;
    op          = 2'($urandom);
    operand     = $urandom; // latched copy must be unaffected
    wait_valid(lat, to);
    if (to) check("timeout", 1, 0);
    r  = result;
    cu = int'(chunks_used);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input logic [1:0] o, input logic [31:0] v);
    logic r, er;
    int   cu, ecu, lat;
    model(o, v, er, ecu);
    do_req(o, v, r, cu, lat);
    check({tag, " result"}, int'(r), int'(er));
    check({tag, " chunks_used"}, cu, ecu);
    check({tag, " latency"}, lat, ecu + 1);
  endtask

  initial begin
    vec_t vecs[9];
    logic r, r0;
    int   cu, cu0, lat;
    bit   to, seen;

    vecs[0] = '{2'd0, 32'hFFFF_FFFF, 1'b1, 4, 5};
    vecs[1] = '{2'd0, 32'hFFFF_FF00, 1'b0, 1, 2};
    vecs[2] = '{2'd1, 32'hFFFF_FF00, 1'b1, 1, 2};
    vecs[3] = '{2'd2, 32'h0000_0000, 1'b0, 4, 5};
    vecs[4] = '{2'd2, 32'h0100_0000, 1'b1, 4, 5};
    vecs[5] = '{2'd3, 32'h0000_0001, 1'b0, 1, 2};
    vecs[6] = '{2'd1, 32'hFFFF_FFFF, 1'b0, 4, 5};
    vecs[7] = '{2'd3, 32'h0000_0000, 1'b1, 4, 5};
    vecs[8] = '{2'd0, 32'h00FF_FFFF, 1'b0, 4, 5};

    rst          = 1'b1;
    start_valid  = 1'b1; // reset must win over a simultaneous request
    op           = 2'd0;
    operand      = '1;
    result_ready = 1'b0;
    repeat (2) @(negedge clk);
    start_valid = 1'b0;
    rst         = 1'b0;
    check("reset start_ready", int'(start_ready), 1);
    check("reset result_valid", int'(result_valid), 0);
    check("reset result", int'(result), 0);
    check("reset chunks_used", int'(chunks_used), 0);
    check("reset busy", int'(busy), 0);

    for (int i = 0; i < 9; i++) begin
      do_req(vecs[i].op, vecs[i].operand, r, cu, lat);
      check($sformatf("vec%0d result", i), int'(r), int'(vecs[i].exp_result));
      check($sformatf("vec%0d chunks_used", i), cu, vecs[i].exp_cu);
      check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d idle after", i), int'(start_ready), 1);
    end

    // Backpressure: hold result_ready low 3 cycles, poke start_valid meanwhile.
    start_valid = 1'b1;
    op          = 2'd0;
    operand     = 32'hFFFF_FFFF;
    @(negedge clk);
    start_valid = 1'b0;
    check("bp busy in run", int'(busy), 1);
    wait_valid(lat, to);
    if (to) check("bp timeout", 1, 0);
    r0  = result;
    cu0 = int'(chunks_used);
    check("bp result", int'(r0), 1);
    check("bp chunks_used", cu0, 4);
    for (int k = 0; k < 3; k++) begin
      start_valid = (k == 1);
      operand     = 32'h0;
      @(negedge clk);
      check("bp valid held", int'(result_valid), 1);
      check("bp result held", int'(result), int'(r0));
      check("bp chunks held", int'(chunks_used), cu0);
      check("bp start_ready low", int'(start_ready), 0);
    end
    start_valid  = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("bp back to idle", int'(busy), 0);
    @(negedge clk);
    check("bp no stray accept", int'(busy), 0);

    // Reset during the second RUN cycle.
    start_valid = 1'b1;
    op          = 2'd0;
    operand     = 32'hFFFF_FFFF;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", int'(busy), 0);
    check("abort start_ready", int'(start_ready), 1);
    check("abort result_valid", int'(result_valid), 0);
    check("abort chunks_used", int'(chunks_used), 0);
    check("abort result", int'(result), 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (result_valid) seen = 1'b1;
    end
    check("abort no valid pulse", int'(seen), 0);
    run_and_check("after abort", 2'd2, 32'h0000_0100);

    for (int i = 0; i < 200; i++) begin
      logic [31:0] v;
      v = $urandom;
      // Bias some chunks to all-ones / all-zeros so late exits occur.
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 1) == 0) v[c*8 +: 8] = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'h00;
      end
      run_and_check("random", 2'($urandom), v);
    end

    for (int o = 0; o < 4; o++) begin
      for (int b = 0; b < 256; b++) begin
        run_and_check($sformatf("sweep op%0d byte%0h", o, b), 2'(o), {8'(b), 24'hFF_FFFF});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reduce_seq.md
REDUCE_SEQ -- requirements
Module: reduce_seq

Interface
- REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits.
- REQ-002 SHALL have parameter NB_IN, default 8: width of the single shared and_nway reduction gate.
- REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
- REQ-005 SHALL have port start_valid, input, 1: a request is presented.
- REQ-006 SHALL have port start_ready, output, 1: the block accepts a request this cycle.
- REQ-007 SHALL have port op, input, 2: reduction opcode. 0=AND, 1=NAND, 2=OR, 3=NOR.
- REQ-008 SHALL have port operand, input, WIDTH: vector to reduce.
- REQ-009 SHALL have port result_valid, output, 1: result is presented.
- REQ-010 SHALL have port result_ready, input, 1: the consumer takes the result.
- REQ-011 SHALL have port result, output, 1: reduced value.
- REQ-012 SHALL have port chunks_used, output, clog2(WIDTH/NB_IN)+1: count of chunks evaluated for the current result.
- REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
- REQ-014 SHALL require WIDTH to be a non-zero multiple of NB_IN and NB_IN >= 2; NCHUNK = WIDTH/NB_IN.
- REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
- REQ-016 SHALL drive start_ready high only in IDLE.
- REQ-017 SHALL, on a handshake (start_valid & start_ready), latch operand and op, set chunk index=0, acc=1, chunks_used=0, and enter RUN the next cycle.
- REQ-018 SHALL present chunk[idx] = operand_reg[idx*NB_IN +: NB_IN] to the and_nway instance in each RUN cycle, bitwise inverted when op is OR or NOR (De Morgan).
- REQ-019 SHALL, in each RUN cycle, set acc <= acc & gate_out, increment chunks_used, and increment idx.
- REQ-020 SHALL exit early: transition RUN->DONE when the updated acc is 0 or idx == NCHUNK-1.
- REQ-021 SHALL make latency from handshake to result_valid equal to chunks_used+1 cycles (minimum 2, maximum NCHUNK+1).
- REQ-022 SHALL drive result in DONE as acc for AND and NOR, and ~acc for NAND and OR.
- REQ-023 SHALL assert result_valid only in DONE, holding result and chunks_used stable until result_ready is high.
- REQ-024 SHALL, on DONE & result_ready, return to IDLE the next cycle; start_ready is therefore low in the handshake cycle and the next request is accepted no earlier than the following cycle.
- REQ-025 SHALL ignore start_valid outside IDLE and SHALL not change its latched operand or op once the request is accepted.
- REQ-026 SHALL treat result_ready as don't-care outside DONE.
- REQ-027 SHALL be the sole user of its and_nway instance; no combinational path from operand to result.

Reset
- REQ-028 SHALL, with rst high at a clock edge, enter IDLE with start_ready=1, result_valid=0, result=0, chunks_used=0, busy=0, acc=1, idx=0.
- REQ-029 SHALL abort any in-flight RUN or DONE on rst and discard its result, with no result_valid pulse after the reset edge.
- REQ-030 SHALL give rst priority over any simultaneous handshake.

Structure
- REQ-031 SHALL take the opcode encodings (AND/NAND/OR/NOR) and FSM state encodings from a shared definitions include file under src/boolean, also used by the bench.
- REQ-032 SHALL instantiate exactly one existing and_nway with NB_IN(NB_IN) as its only sub-module.

Verification (WIDTH=32, NB_IN=8)
- REQ-033 SHALL cover: AND, operand 0xFFFFFFFF -> result=1, chunks_used=4, result_valid 5 cycles after the handshake.
- REQ-034 SHALL cover: AND, operand 0xFFFFFF00 -> early exit, result=0, chunks_used=1, result_valid 2 cycles after the handshake; NAND of the same operand -> result=1.
- REQ-035 SHALL cover: OR, operand 0x00000000 -> result=0, chunks_used=4; OR, operand 0x01000000 -> result=1, chunks_used=4; NOR, operand 0x00000001 -> result=0, chunks_used=1.
- REQ-036 SHALL cover backpressure: result_ready held low for 3 cycles in DONE -> result_valid, result and chunks_used stable; start_valid pulsed during this time is not accepted.
- REQ-037 SHALL cover reset mid-run: rst asserted in the 2nd RUN cycle -> IDLE the next cycle, result_valid never asserted, the following request completes correctly.
- REQ-038 SHALL cover exhaustion: all 256 values of the top byte with the lower 24 bits all ones, for each op, checked against a behavioural reduction.
